// File: rtl/ball_centroid.sv
// Frame centroid of the post-dilate ball mask: accumulates coordinate sums and
// the set-pixel count over one window, then divides to publish the ball centre.
module ball_centroid #(
    parameter int H_ACTIVE   = 320,
    parameter int V_ACTIVE   = 240,
    parameter int MIN_PIXELS = 16
) (
    input  logic        PCLK,
    input  logic        reset,
    input  logic        pix_valid,
    input  logic [8:0]  VtcHCnt,
    input  logic [8:0]  VtcVCnt,
    input  logic        render_i,
    output logic [11:0] center_h,
    output logic [10:0] center_v,
    output logic        found,
    output logic [16:0] pixel_count,
    output logic        center_valid,
    output logic        overrun
);

    localparam int SUM_W     = 25;
    localparam int CNT_W     = 17;
    localparam int DIV_STEPS = 25;

    typedef enum logic [1:0] {
        IDLE_ACC = 2'd0,
        DIVIDE   = 2'd1,
        PUBLISH  = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic             pix_add;
    logic             frame_end;
    logic             accept;
    logic             meets_min;
    logic [SUM_W-1:0] sum_x_reg, sum_y_reg;
    logic [SUM_W-1:0] sum_x_inc, sum_y_inc;
    logic [CNT_W-1:0] cnt_reg, cnt_inc;
    logic [CNT_W-1:0] op_cnt_reg;
    logic             found_pend_reg;
    logic [4:0]       step_reg;
    logic [SUM_W-1:0] sum_inc [2];
    logic [SUM_W-1:0] quo     [2];

    assign pix_add   = pix_valid & render_i;
    assign frame_end = pix_valid && (VtcHCnt == 9'(H_ACTIVE - 1)) && (VtcVCnt == 9'(V_ACTIVE - 1));
    assign accept    = frame_end && (state_reg == IDLE_ACC);

    // Sums including the current pixel, so the frame-end pixel is part of its own frame.
    always_comb begin
        sum_x_inc = sum_x_reg;
        sum_y_inc = sum_y_reg;
        cnt_inc   = cnt_reg;
        if (pix_add) begin
            sum_x_inc = sum_x_reg + SUM_W'(VtcHCnt);
            sum_y_inc = sum_y_reg + SUM_W'(VtcVCnt);
            cnt_inc   = cnt_reg + CNT_W'(1);
        end
    end

    assign meets_min  = (cnt_inc >= CNT_W'(MIN_PIXELS));
    assign sum_inc[0] = sum_x_inc;
    assign sum_inc[1] = sum_y_inc;

    always_ff @(posedge PCLK or posedge reset) begin
        if (reset) begin
            sum_x_reg <= '0;
            sum_y_reg <= '0;
            cnt_reg   <= '0;
        end else if (frame_end) begin
            sum_x_reg <= '0;
            sum_y_reg <= '0;
            cnt_reg   <= '0;
        end else begin
            sum_x_reg <= sum_x_inc;
            sum_y_reg <= sum_y_inc;
            cnt_reg   <= cnt_inc;
        end
    end

    always_ff @(posedge PCLK or posedge reset) begin
        if (reset) begin
            op_cnt_reg     <= '0;
            found_pend_reg <= 1'b0;
            step_reg       <= '0;
            overrun        <= 1'b0;
        end else begin
            if (accept) begin
                op_cnt_reg     <= cnt_inc;
                found_pend_reg <= meets_min;
                step_reg       <= '0;
            end else if (state_reg == DIVIDE) begin
                step_reg <= step_reg + 5'd1;
            end
            // A frame end that cannot be taken is dropped, never queued.
            if (frame_end && (state_reg != IDLE_ACC)) begin
                overrun <= 1'b1;
            end
        end
    end

    always_ff @(posedge PCLK or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE_ACC;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE_ACC: begin
                if (accept) begin
                    state_next = meets_min ? DIVIDE : PUBLISH;
                end
            end
            DIVIDE: begin
                if (step_reg == 5'(DIV_STEPS - 1)) begin
                    state_next = PUBLISH;
                end
            end
            PUBLISH: state_next = IDLE_ACC;
            default: state_next = IDLE_ACC;
        endcase
    end

    // Restoring dividers, one per axis. The dividend shifts out the top while
    // quotient bits shift in at the bottom, so dvd_reg ends up holding the quotient.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_div
            logic [SUM_W-1:0] dvd_reg;
            logic [CNT_W-1:0] rem_reg;
            logic [CNT_W:0]   rem_shift;
            logic             ge;
            logic [CNT_W-1:0] rem_next;

            // The remainder stays below the divisor, so 17-bit modular subtraction is exact.
            always_comb begin
                rem_shift = {rem_reg, dvd_reg[SUM_W-1]};
                ge        = (rem_shift >= {1'b0, op_cnt_reg});
                rem_next  = ge ? (rem_shift[CNT_W-1:0] - op_cnt_reg) : rem_shift[CNT_W-1:0];
            end

            always_ff @(posedge PCLK or posedge reset) begin
                if (reset) begin
                    dvd_reg <= '0;
                    rem_reg <= '0;
                end else if (accept) begin
                    dvd_reg <= sum_inc[gi];
                    rem_reg <= '0;
                end else if (state_reg == DIVIDE) begin
                    dvd_reg <= {dvd_reg[SUM_W-2:0], ge};
                    rem_reg <= rem_next;
                end
            end

            assign quo[gi] = dvd_reg;
        end
    endgenerate

    // The quotient cannot exceed the largest coordinate; saturate rather than wrap.
    always_ff @(posedge PCLK or posedge reset) begin
        if (reset) begin
            center_h     <= '0;
            center_v     <= '0;
            found        <= 1'b0;
            pixel_count  <= '0;
            center_valid <= 1'b0;
        end else begin
            center_valid <= 1'b0;
            if (state_reg == PUBLISH) begin
                center_valid <= 1'b1;
                pixel_count  <= op_cnt_reg;
                found        <= found_pend_reg;
                if (found_pend_reg) begin
                    center_h <= (|quo[0][SUM_W-1:12]) ? '1 : quo[0][11:0];
                    center_v <= (|quo[1][SUM_W-1:11]) ? '1 : quo[1][10:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_ball_centroid.sv
// Directed and randomized frames for ball_centroid, checked against a plain
// arithmetic centroid model; strobes are captured by a monitor with cycle stamps.
module tb_ball_centroid;

    logic        PCLK = 1'b0;
    logic        reset;
    logic        pix_valid;
    logic [8:0]  VtcHCnt;
    logic [8:0]  VtcVCnt;
    logic        render_i;
    logic [11:0] center_h;
    logic [10:0] center_v;
    logic        found;
    logic [16:0] pixel_count;
    logic        center_valid;
    logic        overrun;

    ball_centroid dut (
        .PCLK         (PCLK),
        .reset        (reset),
        .pix_valid    (pix_valid),
        .VtcHCnt      (VtcHCnt),
        .VtcVCnt      (VtcVCnt),
        .render_i     (render_i),
        .center_h     (center_h),
        .center_v     (center_v),
        .found        (found),
        .pixel_count  (pixel_count),
        .center_valid (center_valid),
        .overrun      (overrun)
    );

    always #20 PCLK = ~PCLK;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // Observed strobes
    int s_cyc[$], s_h[$], s_v[$], s_cnt[$], s_found[$];
    // Expected strobes from the model
    int e_cyc[$], e_h[$], e_v[$], e_cnt[$], e_found[$];
    // Set pixels of the frame being built
    int q_h[$], q_v[$];
    int model_h = 0;
    int model_v = 0;

    always @(posedge PCLK) begin
        cyc++;
        #1;
        if (center_valid === 1'b1) begin
            s_cyc.push_back(cyc);
            s_h.push_back(int'(center_h));
            s_v.push_back(int'(center_v));
            s_cnt.push_back(int'(pixel_count));
            s_found.push_back(int'(found));
        end
    end

    task automatic cmp(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Off-window cycles: pix_valid low with junk counters, sometimes the frame-end address.
    task automatic idle();
        pix_valid = 1'b0;
        render_i  = 1'($urandom % 2);
        if ($urandom % 8 == 0) begin
            VtcHCnt = 9'd319;
            VtcVCnt = 9'd239;
        end else begin
            VtcHCnt = 9'($urandom);
            VtcVCnt = 9'($urandom);
        end
    endtask

    task automatic step();
        @(posedge PCLK);
        #1;
        idle();
    endtask

    task automatic pix(input int h, input int v, input bit r);
        pix_valid = 1'b1;
        VtcHCnt   = 9'(h);
        VtcVCnt   = 9'(v);
        render_i  = r;
        if (r) begin
            q_h.push_back(h);
            q_v.push_back(v);
        end
        step();
    endtask

    task automatic end_frame(input bit r, input bit accepted);
        longint sx, sy;
        int n, t;
        pix(319, 239, r);
        t  = cyc;
        n  = q_h.size();
        sx = 0;
        sy = 0;
        foreach (q_h[i]) begin
            sx += q_h[i];
            sy += q_v[i];
        end
        if (accepted) begin
            if (n >= 16) begin
                model_h = int'(sx / n);
                model_v = int'(sy / n);
            end
            e_cyc.push_back(t + ((n >= 16) ? 26 : 1));
            e_h.push_back(model_h);
            e_v.push_back(model_v);
            e_cnt.push_back(n);
            e_found.push_back((n >= 16) ? 1 : 0);
        end
        q_h.delete();
        q_v.delete();
    endtask

    task automatic check_next(input string tag);
        int budget = 0;
        while (s_cyc.size() == 0 && budget < 80) begin
            step();
            budget++;
        end
        vectors++;
        assert (s_cyc.size() > 0) else begin
            miscompares++;
            $error("FAIL %s strobe: observed none expected one", tag);
        end
        if (s_cyc.size() > 0 && e_cyc.size() > 0) begin
            cmp({tag, " latency"}, s_cyc.pop_front(), e_cyc.pop_front());
            cmp({tag, " center_h"}, s_h.pop_front(), e_h.pop_front());
            cmp({tag, " center_v"}, s_v.pop_front(), e_v.pop_front());
            cmp({tag, " pixel_count"}, s_cnt.pop_front(), e_cnt.pop_front());
            cmp({tag, " found"}, s_found.pop_front(), e_found.pop_front());
        end
        $display("frame %s: strobe at cycle %0d, centre (%0d,%0d) count %0d found %0b",
                 tag, cyc, center_h, center_v, pixel_count, found);
    endtask

    task automatic check_quiet(input string tag, input int n);
        repeat (n) step();
        cmp({tag, " extra strobes"}, s_cyc.size(), 0);
    endtask

    task automatic check_zero(input string tag);
        cmp({tag, " center_h"}, int'(center_h), 0);
        cmp({tag, " center_v"}, int'(center_v), 0);
        cmp({tag, " found"}, int'(found), 0);
        cmp({tag, " pixel_count"}, int'(pixel_count), 0);
        cmp({tag, " center_valid"}, int'(center_valid), 0);
        cmp({tag, " overrun"}, int'(overrun), 0);
    endtask

    task automatic rand_frame(input string tag, input int n, input bit r);
        repeat (n) begin
            pix($urandom_range(0, 319), $urandom_range(0, 238), 1'b1);
            if ($urandom % 3 == 0) step();
        end
        end_frame(r, 1'b1);
        check_next(tag);
    endtask

    initial begin
        reset = 1'b1;
        idle();
        repeat (3) @(posedge PCLK);
        #1;
        check_zero("reset");
        reset = 1'b0;
        step();

        // 10x10 square centred at (104.5, 54.5)
        for (int v = 50; v < 60; v++)
            for (int h = 100; h < 110; h++) pix(h, v, 1'b1);
        end_frame(1'b0, 1'b1);
        check_next("square");

        // Below threshold: centre holds
        repeat (15) pix(200, 30, 1'b1);
        end_frame(1'b0, 1'b1);
        check_next("below");

        // Back-to-back: second frame accumulates during the first divide
        for (int v = 50; v < 60; v++)
            for (int h = 100; h < 110; h++) pix(h, v, 1'b1);
        end_frame(1'b0, 1'b1);
        for (int v = 200; v < 210; v++)
            for (int h = 20; h < 30; h++) pix(h, v, 1'b1);
        end_frame(1'b0, 1'b1);
        check_next("b2b_first");
        check_next("b2b_second");

        // Threshold boundaries and random frames
        rand_frame("min16", 16, 1'b0);
        rand_frame("min15", 15, 1'b0);
        rand_frame("empty", 0, 1'b0);
        for (int k = 0; k < 5; k++) rand_frame("rand", $urandom_range(0, 60), 1'($urandom % 2));

        // Second frame end 10 cycles into the divide
        cmp("overrun before", int'(overrun), 0);
        repeat (20) pix($urandom_range(0, 319), $urandom_range(0, 238), 1'b1);
        end_frame(1'b0, 1'b1);
        repeat (5) pix($urandom_range(0, 319), $urandom_range(0, 238), 1'b1);
        repeat (4) step();
        end_frame(1'b0, 1'b0);
        check_next("ovr_first");
        check_quiet("ovr_dropped", 40);
        cmp("overrun sticky", int'(overrun), 1);
        rand_frame("post_ovr", 25, 1'b0);

        // Reset 12 cycles into the divide
        repeat (30) pix($urandom_range(0, 319), $urandom_range(0, 238), 1'b1);
        end_frame(1'b0, 1'b0);
        repeat (12) step();
        reset = 1'b1;
        #1;
        check_zero("rst_div");
        model_h = 0;
        model_v = 0;
        repeat (2) @(posedge PCLK);
        #1;
        reset = 1'b0;
        check_quiet("rst_div", 40);
        rand_frame("after_rst", 40, 1'b0);

        // Full frame of set pixels
        for (int v = 0; v < 240; v++)
            for (int h = 0; h < 320; h++)
                if (!(h == 319 && v == 239)) pix(h, v, 1'b1);
        end_frame(1'b1, 1'b1);
        check_next("full");

        check_quiet("end", 40);
        cmp("pending expectations", e_cyc.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ball_centroid.md
Name: ball_centroid

Overview:
- Sits directly downstream of the dilate stage in the ball-tracking pipeline, in the 25 MHz pixel domain.
- Consumes the cleaned binary mask (Binary_PostProcess) together with the 320x240 window counters.
- Accumulates the coordinate sums and the pixel count of all set pixels over one frame, then runs a multi-cycle divide to produce the ball centre.
- Drives center_h/center_v (the x_value/y_value nets) consumed by weight_cal, Motor_Ctrl and Ball_LostDetect.

Parameters:
- H_ACTIVE, 320, window width; frame-end column is H_ACTIVE-1.
- V_ACTIVE, 240, window height; frame-end row is V_ACTIVE-1.
- MIN_PIXELS, 16, minimum set-pixel count for a valid detection.

Ports:
- PCLK  in  1  pixel clock (clk25).
- reset  in  1  asynchronous, active-high reset.
- pix_valid  in  1  high when VtcHCnt/VtcVCnt address a real window pixel.
- VtcHCnt  in  9  window column, 0..H_ACTIVE-1.
- VtcVCnt  in  9  window row, 0..V_ACTIVE-1.
- render_i  in  1  post-dilate binary pixel; 1 = ball.
- center_h  out  12  ball centre column.
- center_v  out  11  ball centre row.
- found  out  1  1 = last completed frame met MIN_PIXELS.
- pixel_count  out  17  set-pixel count of the last completed frame.
- center_valid  out  1  one-cycle strobe when the outputs above update.
- overrun  out  1  sticky flag: a frame end arrived while the divider was busy.

Behaviour:
- Reset (asynchronous): all accumulators, the divider and all outputs go to 0; FSM goes to IDLE_ACC.
- Accumulation runs every cycle with pix_valid=1 and render_i=1:
  - sum_x += VtcHCnt (25 bits).
  - sum_y += VtcVCnt (25 bits).
  - cnt += 1 (17 bits).
  - Widths cover a full frame of set pixels: 76800*319 < 2^25.
- Frame end is the cycle with pix_valid=1, VtcHCnt=H_ACTIVE-1 and VtcVCnt=V_ACTIVE-1. On that edge:
  - Operands are latched as the sums/count including the current pixel.
  - Accumulators clear to 0 in the same edge, so the next frame accumulates with no gap.
- FSM:
  - IDLE_ACC: wait for frame end.
    - If latched cnt >= MIN_PIXELS, go to DIVIDE.
    - Otherwise go to PUBLISH with found_next=0.
  - DIVIDE: two parallel restoring dividers (sum_x/cnt, sum_y/cnt), one quotient bit per cycle, exactly 25 cycles. Then go to PUBLISH with found_next=1.
  - PUBLISH: one cycle.
    - Write pixel_count and found.
    - If found_next=1, write center_h and center_v from the truncated quotients, zero-extended.
    - If found_next=0, center_h and center_v hold their previous values.
    - center_valid=1 for this cycle only. Return to IDLE_ACC.
- Latency:
  - Frame-end edge at T. Detect path: center_valid high during the cycle after edge T+26.
  - Below-threshold path: center_valid high during the cycle after edge T+1.
- Quotient is truncation (floor); no rounding.
- Frame end while in DIVIDE or PUBLISH:
  - The new frame's operands are discarded and overrun is set.
  - Accumulators still clear, and the in-flight result completes normally.
  - overrun clears only on reset.
- Edge cases:
  - pix_valid=0 cycles never accumulate and never count as frame end, whatever the counter values.
  - cnt=0 is always below threshold, so the divider never sees a zero divisor.
  - Reset asserted mid-DIVIDE aborts the divide; outputs go to 0 and no center_valid is issued.

Test Plan:
- 10x10 square, H 100..109, V 50..59 -> center_valid 27 cycles after frame end (cycle after edge T+26); center_h=104, center_v=54, pixel_count=100, found=1.
- Single frame with 15 set pixels at (200,30) -> center_valid at T+2; found=0, pixel_count=15, center_h/center_v unchanged from the previous frame's (104,54).
- Full frame of render_i=1 -> pixel_count=76800, center_h=159, center_v=119, no accumulator overflow.
- Two back-to-back frames (square at (104,54), then square at (20,200)) -> second strobe reports (24,204); the second frame's accumulation is unaffected by the first frame's divide.
- Force a second frame-end pulse 10 cycles after the first -> overrun=1; first result published correctly; second result dropped.
- Assert reset 12 cycles into DIVIDE -> all outputs 0 immediately, no center_valid; the next full frame produces a correct result.
